// File: rtl/stream_arb.sv
// stream_arb: round-robin packet arbiter merging NI valid/ready streams into one registered output slot.
module stream_arb #(
  parameter int W  = 1,
  parameter int NI = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic [NI-1:0]                i_valid,
  output logic [NI-1:0]                i_ready,
  input  logic [NI-1:0][W-1:0]         i,
  input  logic [NI-1:0]                i_last,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [W-1:0]                 o,
  output logic                         o_last,
  output logic [((NI > 2) ? $clog2(NI) : 1)-1:0] o_id
);
  localparam int IW = (NI > 2) ? $clog2(NI) : 1;
  logic [IW-1:0] r_ptr, r_lock_id, r_id, w_sel;
  logic [IW:0]   w_sum, w_idx;
  logic          r_locked, r_valid, r_last, w_has, w_go;
  logic [W-1:0]  r_data;
  // Unlocked search runs from the highest offset down so the first valid index at or after ptr wins.
  always_comb begin
    w_sel = r_lock_id;
    w_has = i_valid[r_lock_id];
    w_sum = '0;
    w_idx = '0;
    if (!r_locked) begin
      w_has = |i_valid;
      for (int j = NI - 1; j >= 0; j--) begin
        w_sum = {1'b0, r_ptr} + (IW+1)'(j);
        w_idx = (w_sum >= (IW+1)'(NI)) ? w_sum - (IW+1)'(NI) : w_sum;
        if (i_valid[w_idx[IW-1:0]]) w_sel = w_idx[IW-1:0];
      end
    end
  end
  assign w_go    = clk_en && (!r_valid || o_ready) && w_has;
  assign i_ready = w_go ? NI'(1) << w_sel : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_id      <= '0;
      r_locked  <= 1'b0;
      r_lock_id <= '0;
      r_ptr     <= '0;
    end else if (clk_en) begin
      if (w_go) begin
        r_valid   <= 1'b1;
        r_data    <= i[w_sel];
        r_last    <= i_last[w_sel];
        r_id      <= w_sel;
        r_locked  <= !i_last[w_sel];
        r_lock_id <= w_sel;
        if (i_last[w_sel]) r_ptr <= (w_sel == IW'(NI - 1)) ? '0 : w_sel + 1'b1;
      end else if (o_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign o_valid = r_valid;
  assign o       = r_data;
  assign o_last  = r_last;
  assign o_id    = r_id;
endmodule

// File: tb/tb_stream_arb.sv
// tb_stream_arb: scenario tasks drive two arbiters (NI=4 and NI=3); a negedge monitor pops expected beats.
module tb_stream_arb;
  logic clk = 0, rst = 1, en = 1;
  logic [3:0] v4 = '0, ir4, l4 = '0;
  logic [3:0][7:0] d4 = '0;
  logic ov4, ord4 = 1, ol4;
  logic [7:0] o4;
  logic [1:0] id4;
  logic [2:0] v3 = '0, ir3, l3 = '0;
  logic [2:0][7:0] d3 = '0;
  logic ov3, ord3 = 1, ol3;
  logic [7:0] o3;
  logic [1:0] id3;
  logic [10:0] sb4[$], sb3[$];
  logic [10:0] e4, e3;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  stream_arb #(.W(8), .NI(4)) dut4 (.clk(clk), .rst(rst), .clk_en(en), .i_valid(v4), .i_ready(ir4),
    .i(d4), .i_last(l4), .o_valid(ov4), .o_ready(ord4), .o(o4), .o_last(ol4), .o_id(id4));
  stream_arb #(.W(8), .NI(3)) dut3 (.clk(clk), .rst(rst), .clk_en(en), .i_valid(v3), .i_ready(ir3),
    .i(d3), .i_last(l3), .o_valid(ov3), .o_ready(ord3), .o(o3), .o_last(ol3), .o_id(id3));

  always @(negedge clk) begin
    if (!rst && en && ov4 && ord4) begin
      checks++;
      if (sb4.size() == 0) begin
        errors++;
        $display("FAIL sb4 unexpected beat got {last,id,data}=%h expected none", {ol4, id4, o4});
      end else begin
        e4 = sb4.pop_front();
        if ({ol4, id4, o4} !== e4) begin
          errors++;
          $display("FAIL sb4 beat got {last,id,data}=%h expected %h", {ol4, id4, o4}, e4);
        end
      end
    end
    if (!rst && en && ov3 && ord3) begin
      checks++;
      if (sb3.size() == 0) begin
        errors++;
        $display("FAIL sb3 unexpected beat got {last,id,data}=%h expected none", {ol3, id3, o3});
      end else begin
        e3 = sb3.pop_front();
        if ({ol3, id3, o3} !== e3) begin
          errors++;
          $display("FAIL sb3 beat got {last,id,data}=%h expected %h", {ol3, id3, o3}, e3);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ir4(input logic [3:0] exp, input string nm);
    #1;
    checks++;
    if (ir4 !== exp) begin
      errors++;
      $display("FAIL %s i_ready got %b expected %b", nm, ir4, exp);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    checks++;
    if ({ov4, o4, ol4, id4, dut4.r_locked, ov3} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got %h expected 0", {ov4, o4, ol4, id4, dut4.r_locked, ov3});
    end
    chk_ir4(4'b0000, "reset_idle");
  endtask

  task automatic test_round_robin;
    v4 = 4'hF; l4 = 4'hF;
    for (int k = 0; k < 4; k++) d4[k] = 8'h10 + 8'(k);
    for (int n = 0; n < 5; n++) sb4.push_back({1'b1, 2'(n % 4), 8'h10 + 8'(n % 4)});
    for (int n = 0; n < 5; n++) begin
      chk_ir4(4'b0001 << (n % 4), "rr_grant");
      tick;
      checks++;
      if (id4 !== 2'(n % 4) || ov4 !== 1'b1) begin
        errors++;
        $display("FAIL rr_id got %0d/%b expected %0d/1", id4, ov4, n % 4);
      end
    end
    v4 = '0;
    tick;
  endtask

  task automatic test_packet;
    v4 = 4'b0110; l4[2] = 1; d4[2] = 8'h20;
    for (int b = 0; b < 3; b++) sb4.push_back({b == 2, 2'd1, 8'h30 + 8'(b)});
    sb4.push_back({1'b1, 2'd2, 8'h20});
    for (int b = 0; b < 3; b++) begin
      d4[1] = 8'h30 + 8'(b); l4[1] = (b == 2);
      chk_ir4(4'b0010, "pkt_lock");
      tick;
      checks++;
      if (id4 !== 2'd1 || o4 !== 8'h30 + 8'(b)) begin
        errors++;
        $display("FAIL pkt_beat got id=%0d o=%h expected id=1 o=%h", id4, o4, 8'h30 + 8'(b));
      end
    end
    chk_ir4(4'b0100, "pkt_next");
    tick;
    v4 = '0;
    checks++;
    if (id4 !== 2'd2) begin
      errors++;
      $display("FAIL pkt_after got id=%0d expected 2", id4);
    end
    tick;
  endtask

  task automatic test_stall_mid_packet;
    v4 = 4'b0010; d4[1] = 8'h40; l4 = 4'b1001; d4[0] = 8'h03; d4[3] = 8'h33;
    sb4.push_back({1'b0, 2'd1, 8'h40}); sb4.push_back({1'b0, 2'd1, 8'h41});
    sb4.push_back({1'b1, 2'd1, 8'h42}); sb4.push_back({1'b1, 2'd3, 8'h33});
    sb4.push_back({1'b1, 2'd0, 8'h03});
    l4[1] = 0;
    chk_ir4(4'b0010, "stall_first");
    tick;
    v4 = 4'b1001;
    for (int n = 0; n < 2; n++) begin
      chk_ir4(4'b0000, "stall_hold");
      tick;
      checks++;
      if (ov4 !== 1'b0) begin
        errors++;
        $display("FAIL stall_ovalid got %b expected 0", ov4);
      end
    end
    v4 = 4'b1011; d4[1] = 8'h41;
    chk_ir4(4'b0010, "stall_resume");
    tick;
    d4[1] = 8'h42; l4[1] = 1;
    chk_ir4(4'b0010, "stall_last");
    tick;
    v4 = 4'b1001;
    chk_ir4(4'b1000, "stall_rr3");
    tick;
    v4 = 4'b0001;
    chk_ir4(4'b0001, "stall_rr0");
    tick;
    v4 = '0;
    tick;
  endtask

  task automatic test_backpressure;
    v4 = 4'b0100; d4[2] = 8'hA5; l4 = 4'hF;
    sb4.push_back({1'b1, 2'd2, 8'hA5}); sb4.push_back({1'b1, 2'd1, 8'h5A});
    tick;
    ord4 = 0; v4 = 4'b0010; d4[1] = 8'h5A;
    for (int n = 0; n < 3; n++) begin
      chk_ir4(4'b0000, "bp_ready_low");
      tick;
      checks++;
      if ({ov4, id4, o4} !== {1'b1, 2'd2, 8'hA5}) begin
        errors++;
        $display("FAIL bp_hold got %h expected %h", {ov4, id4, o4}, {1'b1, 2'd2, 8'hA5});
      end
    end
    ord4 = 1;
    chk_ir4(4'b0010, "bp_release");
    tick;
    checks++;
    if ({id4, o4} !== {2'd1, 8'h5A}) begin
      errors++;
      $display("FAIL bp_next got %h expected %h", {id4, o4}, {2'd1, 8'h5A});
    end
  endtask

  task automatic test_clk_en;
    en = 0; v4 = 4'b0001; d4[0] = 8'h77;
    sb4.push_back({1'b1, 2'd0, 8'h77});
    for (int n = 0; n < 2; n++) begin
      chk_ir4(4'b0000, "en_low");
      tick;
      checks++;
      if ({ov4, o4} !== {1'b1, 8'h5A}) begin
        errors++;
        $display("FAIL en_hold got %h expected %h", {ov4, o4}, {1'b1, 8'h5A});
      end
    end
    en = 1;
    chk_ir4(4'b0001, "en_high");
    tick;
    v4 = '0;
    tick;
  endtask

  task automatic test_reset_mid_packet;
    v4 = 4'b1000; d4[3] = 8'h90; l4 = 4'b0001; d4[0] = 8'h01;
    chk_ir4(4'b1000, "rstpkt_grant3");
    tick;
    rst = 1; v4 = 4'b1001;
    tick;
    rst = 0;
    #1;
    checks++;
    if ({ov4, dut4.r_locked} !== 2'b00) begin
      errors++;
      $display("FAIL rstpkt_state got %b expected 00", {ov4, dut4.r_locked});
    end
    sb4.push_back({1'b1, 2'd0, 8'h01}); sb4.push_back({1'b1, 2'd3, 8'h91});
    chk_ir4(4'b0001, "rstpkt_req0");
    tick;
    v4 = 4'b1000; l4[3] = 1; d4[3] = 8'h91;
    chk_ir4(4'b1000, "rstpkt_req3");
    tick;
    v4 = '0;
    repeat (2) tick;
  endtask

  task automatic test_wrap;
    v3 = 3'b010; l3 = 3'b111; d3[0] = 8'h60; d3[1] = 8'h61; d3[2] = 8'h62;
    sb3.push_back({1'b1, 2'd1, 8'h61}); sb3.push_back({1'b1, 2'd2, 8'h62});
    sb3.push_back({1'b1, 2'd0, 8'h60});
    tick;
    v3 = 3'b101;
    #1;
    checks++;
    if (ir3 !== 3'b100) begin
      errors++;
      $display("FAIL wrap_first got %b expected 100", ir3);
    end
    tick;
    #1;
    checks++;
    if ({ir3, id3} !== {3'b001, 2'd2}) begin
      errors++;
      $display("FAIL wrap_second got %b expected %b", {ir3, id3}, {3'b001, 2'd2});
    end
    tick;
    v3 = '0;
    checks++;
    if (id3 !== 2'd0) begin
      errors++;
      $display("FAIL wrap_id got %0d expected 0", id3);
    end
    repeat (2) tick;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_packet;
    test_stall_mid_packet;
    test_backpressure;
    test_clk_en;
    test_reset_mid_packet;
    test_wrap;
    repeat (2) tick;
    checks++;
    if (sb4.size() != 0 || sb3.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d/%0d left expected 0/0", sb4.size(), sb3.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
